// File: rtl/cubo_caida_if.sv
// Pixel-side bundle for the falling cube generator: sync-generator coordinates
// and game enable in, pixel flag and cube status out.
interface cubo_caida_if;
    logic       enable;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       cubo_verde;
    logic [9:0] cube_y;
    logic       landed;

    modport master (
        output enable, pixel_x, pixel_y,
        input  cubo_verde, cube_y, landed
    );

    modport slave (
        input  enable, pixel_x, pixel_y,
        output cubo_verde, cube_y, landed
    );
endinterface

// File: rtl/cubo_caida.sv
// Falling green cube for the FallingCubes display. Moves the cube once per
// frame inside vertical blanking, holds it on the floor, respawns it in an
// LFSR-chosen column and flags the pixels it covers (one clock of latency).
//
//  state      | meaning
//  -----------+-------------------------------------------------------
//  ST_IDLE    | cube hidden, waiting for a frame tick with enable high
//  ST_FALLING | cube drops SPEED lines on every frame tick
//  ST_LANDED  | cube parked on the floor, counting HOLD_FRAMES ticks
//  ST_RESPAWN | one cycle: pick a new column, move back to the top
module cubo_caida #(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned CUBE_SIZE   = 16,
    parameter int unsigned SPEED       = 2,
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned X_INIT      = 312,
    parameter logic [9:0]  LFSR_SEED   = 10'h2A5
) (
    input logic        clk,
    input logic        rst_n,
    cubo_caida_if.slave bus
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FALLING = 2'd1;
    localparam logic [1:0] ST_LANDED  = 2'd2;
    localparam logic [1:0] ST_RESPAWN = 2'd3;

    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - CUBE_SIZE);
    localparam logic [10:0] Y_FLOOR = 11'(V_ACTIVE - CUBE_SIZE);
    localparam logic [10:0] SIZE_W  = 11'(CUBE_SIZE);

    logic [1:0]        state;
    logic [9:0]        x;
    logic [9:0]        y;
    logic [9:0]        lfsr;
    logic [HOLD_W-1:0] hold_cnt;
    logic              frame_tick;
    logic              verde_q;
    logic              landed_q;

    logic [10:0] ny;
    logic [10:0] xr_wide;
    logic [10:0] px_w;
    logic [10:0] py_w;
    logic        hit;

    // Arithmetic is carried at 11 bits so x+CUBE_SIZE and y+SPEED cannot wrap.
    assign ny      = {1'b0, y} + 11'(SPEED);
    assign xr_wide = ({1'b0, lfsr} > X_MAX) ? ({1'b0, lfsr} - X_MAX) : {1'b0, lfsr};
    assign px_w    = {1'b0, bus.pixel_x};
    assign py_w    = {1'b0, bus.pixel_y};
    assign hit     = (state != ST_IDLE)
                   && (px_w >= {1'b0, x}) && (px_w < ({1'b0, x} + SIZE_W))
                   && (py_w >= {1'b0, y}) && (py_w < ({1'b0, y} + SIZE_W));

    assign bus.cubo_verde = verde_q;
    assign bus.cube_y     = y;
    assign bus.landed     = landed_q;

    // Frame tick: first pixel of the first blanking line, registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (bus.pixel_y == 10'(V_ACTIVE)) && (bus.pixel_x == 10'd0);
        end
    end

    // Free-running 10-bit maximal-length LFSR (x^10 + x^7 + 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
        end
    end

    // Registered hit test; enable gates it so the cube vanishes on the same edge the FSM parks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            verde_q <= 1'b0;
        end else begin
            verde_q <= bus.enable && hit;
        end
    end

    // Cube motion FSM; enable low overrides any tick in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            x        <= 10'(X_INIT);
            y        <= 10'd0;
            hold_cnt <= '0;
            landed_q <= 1'b0;
        end else begin
            landed_q <= 1'b0;
            if (!bus.enable) begin
                state    <= ST_IDLE;
                hold_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (frame_tick) begin
                            x     <= 10'(X_INIT);
                            y     <= 10'd0;
                            state <= ST_FALLING;
                        end
                    end
                    ST_FALLING: begin
                        if (frame_tick) begin
                            if (ny >= Y_FLOOR) begin
                                y        <= Y_FLOOR[9:0];
                                hold_cnt <= '0;
                                landed_q <= 1'b1;
                                state    <= ST_LANDED;
                            end else begin
                                y <= ny[9:0];
                            end
                        end
                    end
                    ST_LANDED: begin
                        if (frame_tick) begin
                            if (hold_cnt == HOLD_W'(HOLD_FRAMES - 1)) begin
                                state <= ST_RESPAWN;
                            end else begin
                                hold_cnt <= hold_cnt + HOLD_W'(1);
                            end
                        end
                    end
                    default: begin
                        x     <= xr_wide[9:0];
                        y     <= 10'd0;
                        state <= ST_FALLING;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cubo_caida.sv
// Bench for cubo_caida: frame-count model of the cube's life compared every
// cycle, plus hand-computed expectations for start, fall, landing, hold,
// respawn, enable drop and asynchronous reset.
module tb_cubo_caida;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   landed_seen = 0;

    cubo_caida_if bus();

    cubo_caida dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state: cube life measured in frame ticks since spawn.
    bit m_live;
    bit m_resp;
    bit m_tick;
    int m_frames;
    int m_nf;
    int m_x;
    int m_y;
    int m_lfsr;
    bit exp_verde;
    bit exp_landed;

    assign m_nf = m_frames + 1;

    function automatic int lfsr_next(input int v);
        return ((v * 2) & 1023) | (((v >> 9) ^ (v >> 6)) & 1);
    endfunction

    function automatic int respawn_col(input int v);
        return (v > 624) ? v - 624 : v;
    endfunction

    function automatic bit in_box(input int px, input int py, input int bx, input int by);
        return (px >= bx) && (px < bx + 16) && (py >= by) && (py < by + 16);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_live     <= 1'b0;
            m_resp     <= 1'b0;
            m_tick     <= 1'b0;
            m_frames   <= 0;
            m_x        <= 312;
            m_y        <= 0;
            m_lfsr     <= 'h2A5;
            exp_verde  <= 1'b0;
            exp_landed <= 1'b0;
        end else begin
            m_tick     <= (int'(bus.pixel_y) == 480) && (int'(bus.pixel_x) == 0);
            m_lfsr     <= lfsr_next(m_lfsr);
            exp_verde  <= bus.enable && m_live && in_box(int'(bus.pixel_x), int'(bus.pixel_y), m_x, m_y);
            exp_landed <= 1'b0;
            if (!bus.enable) begin
                m_live   <= 1'b0;
                m_resp   <= 1'b0;
                m_frames <= 0;
            end else if (m_resp) begin
                m_x      <= respawn_col(m_lfsr);
                m_y      <= 0;
                m_frames <= 0;
                m_resp   <= 1'b0;
            end else if (m_tick) begin
                if (!m_live) begin
                    m_live   <= 1'b1;
                    m_x      <= 312;
                    m_y      <= 0;
                    m_frames <= 0;
                end else begin
                    m_frames <= m_nf;
                    m_y      <= (2 * m_nf >= 464) ? 464 : 2 * m_nf;
                    if (m_nf == 232) exp_landed <= 1'b1;
                    if (m_nf == 262) m_resp <= 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_verde", int'(bus.cubo_verde), int'(exp_verde));
            chk("cyc_cube_y", int'(bus.cube_y), m_y);
            chk("cyc_landed", int'(bus.landed), int'(exp_landed));
            if (bus.landed) landed_seen++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic drive(input int px, input int py);
        bus.pixel_x = 10'(px);
        bus.pixel_y = 10'(py);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic frame();
        drive(0, 480);
        step();
        drive(700, 500);
        step();
        step();
    endtask

    task automatic probe(input int px, input int py, input int exp, input string nm);
        drive(px, py);
        step();
        chk(nm, int'(bus.cubo_verde), exp);
    endtask

    task automatic probe_box();
        int bx;
        int by;
        bx = m_x;
        by = m_y;
        drive(bx, by);           step();
        drive(bx + 15, by + 15); step();
        drive(bx + 16, by);      step();
        drive(bx - 1, by + 3);   step();
        if (!(bx == 0 && by + 16 == 480)) begin
            drive(bx, by + 16);  step();
        end
        drive(700, 500);
    endtask

    initial begin
        int first;
        bus.enable = 1'b0;
        drive(700, 500);
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_verde", int'(bus.cubo_verde), 0);
        chk("rst_cube_y", int'(bus.cube_y), 0);
        chk("rst_landed", int'(bus.landed), 0);
        rst_n = 1'b1;
        step();

        // Idle with enable low: ticks do nothing
        frame();
        probe(312, 0, 0, "idle_hidden");
        frame();
        chk("idle_cube_y", int'(bus.cube_y), 0);
        chk("idle_no_landed", landed_seen, 0);

        // Start and first fall steps
        bus.enable = 1'b1;
        frame();
        chk("start_y", int'(bus.cube_y), 0);
        probe(312, 0, 1, "start_hit");
        frame();
        chk("fall_y2", int'(bus.cube_y), 2);
        frame();
        chk("fall_y4", int'(bus.cube_y), 4);
        probe(312, 4, 1, "hit_312_4");
        probe(328, 4, 0, "miss_328_4");
        probe(312, 20, 0, "miss_312_20");
        probe(327, 19, 1, "hit_327_19");
        probe(311, 4, 0, "miss_311_4");

        // Fall to 462, then clamp at the floor
        repeat (229) begin
            frame();
            probe_box();
        end
        chk("pre_land_y", int'(bus.cube_y), 462);
        chk("pre_land_pulses", landed_seen, 0);
        frame();
        chk("land_y", int'(bus.cube_y), 464);
        chk("land_pulses", landed_seen, 1);
        probe(312, 464, 1, "land_hit");
        probe(312, 463, 0, "land_miss_above");

        // Hold for 30 frames, respawn on the 30th
        repeat (29) begin
            frame();
            probe_box();
        end
        chk("hold_y", int'(bus.cube_y), 464);
        chk("hold_pulses", landed_seen, 1);
        frame();
        chk("respawn_y", int'(bus.cube_y), 0);
        first = -1;
        for (int c = 0; c < 640; c++) begin
            drive(c, 0);
            step();
            if (bus.cubo_verde && first < 0) first = c;
        end
        drive(700, 500);
        chk("respawn_col_model", first, m_x);
        chk("respawn_col_range", int'(first >= 0 && first <= 624), 1);

        // Fall to y=100, then drop enable
        repeat (50) begin
            frame();
            probe_box();
        end
        chk("drop_pre_y", int'(bus.cube_y), 100);
        drive(m_x, 100);
        bus.enable = 1'b0;
        step();
        chk("drop_hidden", int'(bus.cubo_verde), 0);
        frame();
        probe(m_x, 100, 0, "drop_still_hidden");
        bus.enable = 1'b1;
        frame();
        chk("restart_y", int'(bus.cube_y), 0);
        probe(312, 0, 1, "restart_hit");
        probe(311, 0, 0, "restart_miss_left");

        // Land again, then async reset while parked
        landed_seen = 0;
        repeat (232) frame();
        chk("reland_y", int'(bus.cube_y), 464);
        repeat (5) frame();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_verde", int'(bus.cubo_verde), 0);
        chk("arst_cube_y", int'(bus.cube_y), 0);
        chk("arst_landed", int'(bus.landed), 0);
        chk("arst_lfsr", int'(dut.lfsr), 'h2A5);
        #1 rst_n = 1'b1;
        @(negedge clk);
        frame();
        chk("arst_pulses", landed_seen, 1);
        chk("post_rst_y", int'(bus.cube_y), 0);
        probe(312, 0, 1, "post_rst_hit");
        frame();
        chk("post_rst_y2", int'(bus.cube_y), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
